// File: rtl/inject_sched.sv
// inject_sched: test-traffic scheduler for the NoC bench.
//
// Drives one {valid, payload} packet onto a single router slice of a flat
// per-router injection bus, waits for that router's ready, then idles for GAP
// cycles. In sweep mode (mode=1) it steps round-robin through every router,
// re-driving the same payload, until stop is seen.
//
// Optional feature (macro HEX_DISPLAY_EN): adds hex_router, an active-low
// 7-segment code (a in bit 6 .. g in bit 0) of cur_router mod 10.
//
// Ports:
//   clk, rst      clock (rising edge) and asynchronous active-high reset
//   start         single-cycle start request, honoured only in IDLE
//   stop          level-sampled abort
//   mode          0 = single packet, 1 = sweep all routers
//   sel_router    first/only target router index
//   sel_data      packet payload
//   router_ready  per-router accept
//   out_bus       injection bus, slice i = bits [i*PKT_W +: PKT_W]
//   busy          high whenever not IDLE
//   cur_router    current target index
//   sent_cnt      accepted packets, wraps
//   err           sticky; bit0 = ready timeout, bit1 = bad router index
module inject_sched #(
  parameter int unsigned ROUTERS = 36,
  parameter int unsigned PKT_W   = 13,
  parameter int unsigned RID_W   = 6,
  parameter int unsigned GAP     = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     mode,
  input  logic [RID_W-1:0]         sel_router,
  input  logic [PKT_W-2:0]         sel_data,
  input  logic [ROUTERS-1:0]       router_ready,
  output logic [ROUTERS*PKT_W-1:0] out_bus,
  output logic                     busy,
  output logic [RID_W-1:0]         cur_router,
  output logic [15:0]              sent_cnt,
  output logic [1:0]               err
`ifdef HEX_DISPLAY_EN
  ,
  output logic [6:0]               hex_router
`endif
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StDrive = 2'd1;
  localparam logic [1:0] StGap   = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [RID_W-1:0]         cur_q, cur_d;
  logic [PKT_W-2:0]         payload_q, payload_d;
  logic [15:0]              sent_q, sent_d;
  logic [1:0]               err_q, err_d;
  logic [7:0]               wait_q, wait_d;
  logic [7:0]               gap_q, gap_d;
  logic [ROUTERS*PKT_W-1:0] out_q, out_d;
  logic                     busy_q, busy_d;
  logic                     accept;
  logic                     sel_ok;

  assign accept = router_ready[cur_q];
  // Widen by one bit so ROUTERS == 2**RID_W still compares correctly.
  assign sel_ok = {1'b0, sel_router} < (RID_W + 1)'(ROUTERS);

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    payload_d = payload_q;
    sent_d    = sent_q;
    err_d     = err_q;
    wait_d    = wait_q;
    gap_d     = gap_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (sel_ok) begin
            cur_d     = sel_router;
            payload_d = sel_data;
            err_d     = 2'b00;
            wait_d    = 8'd0;
            state_d   = StDrive;
          end else begin
            err_d[1] = 1'b1;
          end
        end
      end
      StDrive: begin
        if (accept) begin
          // Acceptance wins over a simultaneous stop; stop only skips the gap.
          sent_d  = sent_q + 16'd1;
          gap_d   = 8'(GAP - 1);
          state_d = stop ? StIdle : StGap;
        end else if (stop) begin
          state_d = StIdle;
        end else if (wait_q == 8'(TIMEOUT - 1)) begin
          err_d[0] = 1'b1;
          gap_d    = 8'(GAP - 1);
          state_d  = StGap;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StGap: begin
        if (stop) begin
          state_d = StIdle;
        end else if (gap_q == 8'd0) begin
          if (mode) begin
            cur_d   = (cur_q == RID_W'(ROUTERS - 1)) ? '0 : cur_q + RID_W'(1);
            wait_d  = 8'd0;
            state_d = StDrive;
          end else begin
            state_d = StIdle;
          end
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus is a pure function of the next state, so only the target slice is
  // ever non-zero and only while DRIVE.
  always_comb begin
    out_d = '0;
    for (int i = 0; i < int'(ROUTERS); i++) begin
      if (state_d == StDrive && cur_d == RID_W'(i)) begin
        out_d[i*PKT_W +: PKT_W] = {1'b1, payload_d};
      end
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cur_q     <= '0;
      payload_q <= '0;
      sent_q    <= '0;
      err_q     <= '0;
      wait_q    <= '0;
      gap_q     <= '0;
      out_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      payload_q <= payload_d;
      sent_q    <= sent_d;
      err_q     <= err_d;
      wait_q    <= wait_d;
      gap_q     <= gap_d;
      out_q     <= out_d;
      busy_q    <= busy_d;
    end
  end

  assign out_bus    = out_q;
  assign busy       = busy_q;
  assign cur_router = cur_q;
  assign sent_cnt   = sent_q;
  assign err        = err_q;

`ifdef HEX_DISPLAY_EN
  function automatic logic [6:0] seg7_n(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
    return ~seg;
  endfunction

  logic [6:0] hex_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex_q <= seg7_n(4'd0);
    end else begin
      hex_q <= seg7_n(4'(int'(cur_d) % 10));
    end
  end

  assign hex_router = hex_q;
`endif

endmodule

// File: tb/tb_inject_sched.sv
// Self-checking bench for inject_sched: scenario tasks with inline checks,
// plus a packet scoreboard (expected packets queued at stimulus time, observed
// packets captured by a bus monitor, compared in test_scoreboard).
module tb_inject_sched;
  localparam int ROUTERS = 36;
  localparam int PKT_W   = 13;
  localparam int RID_W   = 6;
  localparam int GAP     = 16;
  localparam int TIMEOUT = 255;

  logic                     clk;
  logic                     rst;
  logic                     start;
  logic                     stop;
  logic                     mode;
  logic [RID_W-1:0]         sel_router;
  logic [PKT_W-2:0]         sel_data;
  logic [ROUTERS-1:0]       router_ready;
  logic [ROUTERS*PKT_W-1:0] out_bus;
  logic                     busy;
  logic [RID_W-1:0]         cur_router;
  logic [15:0]              sent_cnt;
  logic [1:0]               err;
`ifdef HEX_DISPLAY_EN
  logic [6:0]               hex_router;
`endif

  inject_sched #(
    .ROUTERS (ROUTERS),
    .PKT_W   (PKT_W),
    .RID_W   (RID_W),
    .GAP     (GAP),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .mode         (mode),
    .sel_router   (sel_router),
    .sel_data     (sel_data),
    .router_ready (router_ready),
    .out_bus      (out_bus),
    .busy         (busy),
    .cur_router   (cur_router),
    .sent_cnt     (sent_cnt),
    .err          (err)
`ifdef HEX_DISPLAY_EN
    ,
    .hex_router   (hex_router)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         rid;
    logic [12:0] val;
    int         len;
  } pkt_t;

  pkt_t exp_q[$];
  pkt_t obs_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int exp_sent = 0;

  // Bus monitor: records each packet (slice, value, cycles visible).
  int          mon_idx = -1;
  logic [12:0] mon_val = '0;
  int          mon_len = 0;
  int          multi_viol = 0;

  always @(negedge clk) begin
    int          idx;
    int          hits;
    logic [12:0] v;
    idx  = -1;
    hits = 0;
    v    = '0;
    for (int i = 0; i < ROUTERS; i++) begin
      if (out_bus[i*PKT_W +: PKT_W] != '0) begin
        idx = i;
        v   = out_bus[i*PKT_W +: PKT_W];
        hits++;
      end
    end
    if (hits > 1) multi_viol++;
    if (mon_idx >= 0 && (idx != mon_idx || v != mon_val)) begin
      obs_q.push_back('{rid: mon_idx, val: mon_val, len: mon_len});
    end
    if (idx >= 0) begin
      if (idx == mon_idx && v == mon_val) mon_len++;
      else mon_len = 1;
    end
    mon_idx = idx;
    mon_val = v;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_sent = 0;
  endtask

  task automatic test_reset();
    start = 0; stop = 0; mode = 0; sel_router = '0; sel_data = '0; router_ready = '0;
    reset_dut();
    n_checks++;
    if (out_bus !== '0 || busy !== 1'b0 || cur_router !== '0 || sent_cnt !== 16'd0 ||
        err !== 2'b00)
      $display("FAIL reset: bus=%0h busy=%0b cur=%0d sent=%0d err=%b want all 0",
               out_bus, busy, cur_router, sent_cnt, err);
    else n_pass++;
`ifdef HEX_DISPLAY_EN
    n_checks++;
    if (hex_router !== ~7'b1111110)
      $display("FAIL reset_hex: got %b want %b", hex_router, ~7'b1111110);
    else n_pass++;
`endif
  endtask

  task automatic test_single();
    logic [ROUTERS*PKT_W-1:0] eb;
    eb = '0;
    eb[5*PKT_W +: PKT_W] = 13'h10A3;
    mode = 0; sel_router = 6'd5; sel_data = 12'h0A3; start = 1;
    exp_q.push_back('{rid: 5, val: 13'h10A3, len: 1});
    cyc(1);
    start = 0;
    n_checks++;
    if (out_bus !== eb || busy !== 1'b1)
      $display("FAIL single_drive: bus=%0h busy=%0b want bus=%0h busy=1", out_bus, busy, eb);
    else n_pass++;
    router_ready[5] = 1'b1;
    cyc(1);
    router_ready = '0;
    exp_sent++;
    n_checks++;
    if (out_bus !== '0 || sent_cnt !== 16'(exp_sent))
      $display("FAIL single_accept: bus=%0h sent=%0d want bus=0 sent=%0d",
               out_bus, sent_cnt, exp_sent);
    else n_pass++;
    cyc(GAP - 1);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL single_gap_busy: got %0b want 1", busy);
    else n_pass++;
    cyc(1);
    n_checks++;
    if (busy !== 1'b0 || err !== 2'b00)
      $display("FAIL single_idle: busy=%0b err=%b want busy=0 err=00", busy, err);
    else n_pass++;
`ifdef HEX_DISPLAY_EN
    n_checks++;
    if (hex_router !== ~7'b1011011)
      $display("FAIL single_hex: got %b want %b", hex_router, ~7'b1011011);
    else n_pass++;
`endif
  endtask

  task automatic test_timeout();
    mode = 0; sel_router = 6'd7; sel_data = 12'h5C1; router_ready = '0; start = 1;
    exp_q.push_back('{rid: 7, val: 13'h15C1, len: TIMEOUT});
    cyc(1);
    start = 0;
    cyc(TIMEOUT - 1);
    n_checks++;
    if (out_bus[7*PKT_W +: PKT_W] !== 13'h15C1 || err !== 2'b00)
      $display("FAIL timeout_hold: slice=%0h err=%b want slice=15c1 err=00",
               out_bus[7*PKT_W +: PKT_W], err);
    else n_pass++;
    cyc(1);
    n_checks++;
    if (out_bus !== '0 || err !== 2'b01 || sent_cnt !== 16'(exp_sent) || busy !== 1'b1)
      $display("FAIL timeout_expire: bus=%0h err=%b sent=%0d busy=%0b want 0/01/%0d/1",
               out_bus, err, sent_cnt, busy, exp_sent);
    else n_pass++;
    cyc(GAP);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL timeout_idle: busy=%0b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_bad_index();
    reset_dut();
    mode = 0; sel_router = 6'd40; sel_data = 12'h111; start = 1;
    cyc(1);
    start = 0;
    n_checks++;
    if (err !== 2'b10 || busy !== 1'b0 || out_bus !== '0)
      $display("FAIL bad_index: err=%b busy=%0b bus=%0h want 10/0/0", err, busy, out_bus);
    else n_pass++;
    cyc(2);
    sel_router = 6'd3; sel_data = 12'h222; start = 1;
    exp_q.push_back('{rid: 3, val: 13'h1222, len: 1});
    cyc(1);
    start = 0;
    n_checks++;
    if (err !== 2'b00 || busy !== 1'b1 || cur_router !== 6'd3)
      $display("FAIL bad_index_clear: err=%b busy=%0b cur=%0d want 00/1/3", err, busy, cur_router);
    else n_pass++;
    stop = 1;
    cyc(1);
    stop = 0;
    cyc(1);
  endtask

  task automatic test_sweep();
    int base;
    base = exp_sent;
    mode = 1; sel_router = 6'd34; sel_data = 12'hBEE; router_ready = '1; start = 1;
    exp_q.push_back('{rid: 34, val: 13'h1BEE, len: 1});
    exp_q.push_back('{rid: 35, val: 13'h1BEE, len: 1});
    exp_q.push_back('{rid: 0,  val: 13'h1BEE, len: 1});
    exp_q.push_back('{rid: 1,  val: 13'h1BEE, len: 1});
    cyc(1);
    start = 0;
    for (int k = 0; k < 200 && sent_cnt != 16'(base + 4); k++) cyc(1);
    exp_sent = base + 4;
    n_checks++;
    if (sent_cnt !== 16'(exp_sent) || cur_router !== 6'd1 || busy !== 1'b1)
      $display("FAIL sweep_count: sent=%0d cur=%0d busy=%0b want %0d/1/1",
               sent_cnt, cur_router, busy, exp_sent);
    else n_pass++;
    cyc(3);
    stop = 1;
    cyc(1);
    stop = 0; mode = 0; router_ready = '0;
    n_checks++;
    if (busy !== 1'b0 || out_bus !== '0 || sent_cnt !== 16'(exp_sent) || err !== 2'b00)
      $display("FAIL sweep_stop: busy=%0b bus=%0h sent=%0d err=%b want 0/0/%0d/00",
               busy, out_bus, sent_cnt, err, exp_sent);
    else n_pass++;
    cyc(1);
  endtask

  task automatic test_stop_drive();
    mode = 0; sel_router = 6'd10; sel_data = 12'h3AB; router_ready = '0; start = 1;
    exp_q.push_back('{rid: 10, val: 13'h13AB, len: 3});
    cyc(1);
    start = 0;
    cyc(2);
    stop = 1;
    cyc(1);
    stop = 0;
    n_checks++;
    if (out_bus !== '0 || busy !== 1'b0 || sent_cnt !== 16'(exp_sent))
      $display("FAIL stop_drive: bus=%0h busy=%0b sent=%0d want 0/0/%0d",
               out_bus, busy, sent_cnt, exp_sent);
    else n_pass++;
    cyc(1);
    sel_router = 6'd11; sel_data = 12'h044; start = 1;
    exp_q.push_back('{rid: 11, val: 13'h1044, len: 1});
    cyc(1);
    start = 0; router_ready[11] = 1'b1; stop = 1;
    cyc(1);
    stop = 0; router_ready = '0;
    exp_sent++;
    n_checks++;
    if (out_bus !== '0 || busy !== 1'b0 || sent_cnt !== 16'(exp_sent))
      $display("FAIL stop_accept_same_edge: bus=%0h busy=%0b sent=%0d want 0/0/%0d",
               out_bus, busy, sent_cnt, exp_sent);
    else n_pass++;
    cyc(1);
  endtask

  task automatic test_async_reset();
    mode = 0; sel_router = 6'd20; sel_data = 12'h7E7; router_ready = '0; start = 1;
    exp_q.push_back('{rid: 20, val: 13'h17E7, len: 1});
    cyc(1);
    start = 0;
    #5;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_bus !== '0 || busy !== 1'b0 || sent_cnt !== 16'd0 || err !== 2'b00)
      $display("FAIL async_reset: bus=%0h busy=%0b sent=%0d err=%b want all 0",
               out_bus, busy, sent_cnt, err);
    else n_pass++;
    #10;
    rst = 1'b0;
    exp_sent = 0;
    cyc(2);
  endtask

  task automatic test_scoreboard();
    pkt_t e;
    pkt_t o;
    n_checks++;
    if (obs_q.size() != exp_q.size())
      $display("FAIL sb_count: observed %0d packets want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_checks++;
      if (o.rid != e.rid || o.val !== e.val || o.len != e.len)
        $display("FAIL sb_packet: got rid=%0d val=%0h len=%0d want rid=%0d val=%0h len=%0d",
                 o.rid, o.val, o.len, e.rid, e.val, e.len);
      else n_pass++;
    end
    n_checks++;
    if (multi_viol != 0) $display("FAIL one_slice: %0d cycles multi-slice want 0", multi_viol);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_timeout();
    test_bad_index();
    test_sweep();
    test_stop_drive();
    test_async_reset();
    test_scoreboard();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/inject_sched.md
Name: inject_sched

Overview:
- Test-traffic scheduler for the NoC bench.
- Injects 13-bit packets ({valid, 12-bit payload}) into one router slice of a flat per-router injection bus.
- Waits for that router's ready; supports single-shot and round-robin sweep over all routers.
- Sits between the board switch/key front-end and the router array; reports progress and errors.

Parameters:
ROUTERS, 36, number of routers in the network.
PKT_W, 13, packet width; bit PKT_W-1 = valid flag, bits PKT_W-2:0 = payload.
RID_W, 6, router index width; must satisfy 2**RID_W >= ROUTERS.
GAP, 16, idle cycles inserted after each packet, 1..255.
TIMEOUT, 255, maximum cycles waiting for ready, 1..255.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  single-cycle start request
stop  in  1  abort/stop request, level-sampled
mode  in  1  0 = single packet, 1 = sweep all routers
sel_router  in  RID_W  first/only target router index
sel_data  in  PKT_W-1  payload
router_ready  in  ROUTERS  per-router accept
out_bus  out  ROUTERS*PKT_W  slice i = bits [i*PKT_W +: PKT_W]
busy  out  1  high in any state other than IDLE
cur_router  out  RID_W  current target index
sent_cnt  out  16  accepted packets, wraps at 65535->0
err  out  2  sticky; bit0 = timeout, bit1 = bad router index

Behaviour:
- Reset (async, active-high): FSM = IDLE; out_bus, busy, cur_router, sent_cnt, err, and internal counters all 0. Asserting rst mid-packet clears the bus immediately, without waiting for a clk edge.
- All outputs are registered. At most one bus slice is non-zero at any time.
- FSM states: IDLE, DRIVE, GAP.
- IDLE:
  - start=1 and sel_router < ROUTERS: latch sel_router into cur_router and sel_data into the payload register; clear err; move to DRIVE.
  - From the next edge: slice cur_router = {1, payload}; busy = 1.
  - start=1 and sel_router >= ROUTERS: set err[1]; stay in IDLE.
  - start is ignored in every other state.
- DRIVE:
  - Slice is held constant.
  - Acceptance = router_ready[cur_router] high at a clk edge. On that edge: sent_cnt += 1; load the gap counter; move to GAP. The slice is 0 from that edge on (exactly one acceptance per packet).
  - Wait counter increments each DRIVE cycle without acceptance. If it reaches TIMEOUT: set err[0], clear the slice, move to GAP, sent_cnt unchanged.
  - stop=1 (and no acceptance that edge): clear the slice, go to IDLE, sent_cnt unchanged.
  - Acceptance and stop on the same edge: acceptance counts, then go to IDLE.
- GAP:
  - Bus all-zero for GAP cycles.
  - stop=1: go to IDLE immediately.
  - At end of gap:
    - mode=0: go to IDLE.
    - mode=1: cur_router = cur_router+1, wrapping ROUTERS-1 -> 0; re-drive the same payload; go to DRIVE.
  - mode is sampled at the end of the gap, so it can be changed mid-sweep.
- A sweep runs until stop; the sweep wrap itself is not an error.
- sent_cnt is never cleared except by rst.

Optional Feature:
HEX_DISPLAY_EN
- Defined: adds output hex_router[6:0] = active-low 7-segment code of cur_router mod 10. Segments are ordered a..g with a in bit 6; e.g. 0 -> ~7'b1111110, 8 -> ~7'b1111111. Registered; resets to the code for 0.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- Single packet, ready immediate: rst, mode=0, sel_router=5, sel_data=12'h0A3, pulse start, router_ready[5]=1 at the second edge after start -> slice 5 = 13'h10A3 for exactly 1 cycle; all other slices 0; sent_cnt=1; busy drops after GAP=16 cycles.
- Timeout: sel_router=7, router_ready=0 -> slice 7 held for 255 cycles, then 0; err=2'b01; sent_cnt=0; IDLE after the gap.
- Bad index: sel_router=40, start -> err=2'b10, busy stays 0, bus stays 0. A following start with sel_router=3 clears err.
- Sweep wrap: mode=1, sel_router=34, all ready=1 -> targets 34, 35, 0, 1 in that order; sent_cnt=4 after four packets; stop during the 4th GAP -> IDLE, bus 0.
- Stop in DRIVE: ready=0, assert stop on the 3rd DRIVE cycle -> slice cleared next edge, busy=0, sent_cnt unchanged. Same-edge ready+stop -> counted, then IDLE.
- Async reset mid-DRIVE: assert rst between clk edges -> out_bus=0 and busy=0 immediately.
